dma_bench_replayer: RTL and testbench
=====================================

Name: dma_bench_replayer

Overview:
Parametrised successor of the DMA benchmarking descriptor faker. Sits between the descriptor register file and the DMA engine. It captures one user descriptor and replays it a runtime-configured number of times. Replay modes are fixed-address, sequential, and sequential-with-window-wrap. It reports busy/done status and the elapsed cycles for the benchmark.

Parameters:
C_ITER_WIDTH, 32, width of the iteration count and counters.
C_ADDR_WIDTH, 64, width of the descriptor address and size.
C_CYC_WIDTH, 48, width of the elapsed-cycle counter, which saturates.

Ports:
CLK  in  1  clock.
RST_N  in  1  reset; one clock, synchronous, active-low.
CFG_MODE  in  2  0=passthrough, 1=fixed address, 2=sequential, 3=sequential with window wrap.
CFG_NITERATIONS  in  C_ITER_WIDTH  replay count; a value of 0 is treated as 1.
CFG_WINDOW_SIZE  in  C_ADDR_WIDTH  wrap window in bytes for mode 3; a value of 0 behaves as mode 2.
ORIGINAL_CONTROL_BYTE  in  8  engine control/status; bit 3 = end of operation (EOP).
FAKED_CONTROL_BYTE  out  8  control byte presented to the user side.
ORIGINAL_ENGINE_VALID  in  1  user starts the engine.
FAKED_ENGINE_VALID  out  1  engine valid presented to the DMA engine.
ORIGINAL_SIZE_AT_DESCRIPTOR  in  C_ADDR_WIDTH  descriptor size.
ORIGINAL_ADDR_AT_DESCRIPTOR  in  C_ADDR_WIDTH  descriptor address.
FAKED_SIZE_AT_DESCRIPTOR  out  C_ADDR_WIDTH  replayed size.
FAKED_ADDR_AT_DESCRIPTOR  out  C_ADDR_WIDTH  replayed address.
BUSY  out  1  high while in RUN.
DONE  out  1  one-cycle pulse after the last iteration.
ITERATIONS_DONE  out  C_ITER_WIDTH  number of completed iterations in the current or last run.
ELAPSED_CYCLES  out  C_CYC_WIDTH  cycles from RUN entry to the final EOP, inclusive.
MIN_ITER_CYCLES  out  C_CYC_WIDTH  shortest iteration; see Optional Feature.
MAX_ITER_CYCLES  out  C_CYC_WIDTH  longest iteration; see Optional Feature.

Behaviour:
- Reset, synchronous when RST_N=0 at a CLK edge:
  - state=IDLE; all registered outputs are 0.
  - iteration register = 1; ITERATIONS_DONE = 0; ELAPSED_CYCLES = 0.
  - MIN_ITER_CYCLES = all-ones; MAX_ITER_CYCLES = 0.
- Reset mid-RUN: FAKED_ENGINE_VALID is low after that edge; no DONE pulse.
- Mode 0 (the latched mode, or CFG_MODE while IDLE):
  - All FAKED_* outputs are combinational copies of the ORIGINAL_* inputs.
  - The state machine stays in IDLE; BUSY=0.
- States: IDLE, RUN, FINISH.
- IDLE:
  - Each cycle, size_r/addr_r follow the ORIGINAL_* inputs.
  - FAKED_ENGINE_VALID=0; iteration register = 1.
  - When ORIGINAL_ENGINE_VALID=1 and CFG_MODE!=0:
    - go to RUN;
    - latch mode, niter (0 becomes 1), window, and base = ORIGINAL_ADDR_AT_DESCRIPTOR;
    - FAKED_ENGINE_VALID=1 from the next cycle;
    - clear ELAPSED_CYCLES and ITERATIONS_DONE.
- RUN:
  - ELAPSED_CYCLES increments each cycle and saturates at all-ones.
  - CFG_* changes are ignored (configuration is latched).
  - On EOP, and iteration < niter:
    - iteration++ and ITERATIONS_DONE++;
    - size_r <= ORIGINAL_SIZE_AT_DESCRIPTOR;
    - address update by mode:
      - mode 1: addr_r <= ORIGINAL_ADDR_AT_DESCRIPTOR.
      - mode 2: addr_r <= addr_r + size_r, modulo 2^C_ADDR_WIDTH.
      - mode 3: nxt = addr_r + size_r; if (nxt - base) + size_r > window then addr_r <= base, else addr_r <= nxt.
  - On EOP, and iteration == niter:
    - ITERATIONS_DONE++; go to FINISH;
    - FAKED_ENGINE_VALID=0 next cycle.
- FINISH: one cycle; DONE=1; return to IDLE. Statistics hold until the next run starts.
- FAKED_CONTROL_BYTE, in modes 1 to 3, is combinational:
  - {4'h0, EOP && state==RUN && iteration==niter, 3'h0}.
  - Intermediate EOPs are hidden from the user.
- Simultaneous ORIGINAL_ENGINE_VALID during RUN/FINISH is ignored; a new run needs IDLE.
- An EOP seen in IDLE or FINISH is ignored.

Optional Feature:
- Macro: DMA_BENCH_ITER_STATS_EN.
- Defined:
  - A per-iteration cycle counter resets at RUN entry and after each EOP.
  - On each EOP, MIN_ITER_CYCLES and MAX_ITER_CYCLES update with the count including the EOP cycle.
  - Both statistics reset at RUN entry.
- Undefined: MIN_ITER_CYCLES and MAX_ITER_CYCLES are tied to 0 and no counter logic is built.

Decomposition:
- Package dma_bench_pkg holds:
  - mode enum (MODE_PASS, MODE_FIXED, MODE_SEQ, MODE_WRAP);
  - state enum (IDLE, RUN, FINISH);
  - constant C_EOP_BIT=3.
- Sub-module dma_bench_addr_gen is combinational and computes the next address from mode, addr, size, base and window.

Test Plan:
- Mode 1, niter=4, addr=0x1000, size=256, EOP every 10 cycles:
  - 4 EOPs seen; FAKED_ADDR stays 0x1000 throughout;
  - FAKED_CONTROL_BYTE=0x08 only on the 4th EOP;
  - DONE pulses once; ITERATIONS_DONE=4.
- Mode 2, niter=3, addr=0x2000, size=0x100:
  - FAKED_ADDR sequence 0x2000, 0x2100, 0x2200.
- Mode 3, window=0x300, addr=0x0, size=0x100, niter=5:
  - FAKED_ADDR sequence 0x0, 0x100, 0x200, 0x0, 0x100.
- Mode 0: toggle the ORIGINAL_* inputs → FAKED_* outputs match them in the same cycle; BUSY stays 0.
- niter=0, mode 1 → one iteration, DONE after the first EOP; RST_N low mid-RUN → FAKED_ENGINE_VALID=0 next edge, no DONE.
- DMA_BENCH_ITER_STATS_EN with EOP gaps of 5, 9 and 7 cycles → MIN=5, MAX=9; ELAPSED_CYCLES=21.

Source files
------------

// File: rtl/dma_bench_pkg.sv
// Shared types and constants for the DMA benchmark descriptor replayer.
package dma_bench_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_FIXED = 2'd1,
    MODE_SEQ   = 2'd2,
    MODE_WRAP  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int C_EOP_BIT = 3;

endpackage

// File: rtl/dma_bench_addr_gen.sv
// Combinational next-descriptor-address generator for the replay modes.
module dma_bench_addr_gen
  import dma_bench_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 64
) (
  input  logic [1:0]              mode,
  input  logic [C_ADDR_WIDTH-1:0] addr,
  input  logic [C_ADDR_WIDTH-1:0] size,
  input  logic [C_ADDR_WIDTH-1:0] base,
  input  logic [C_ADDR_WIDTH-1:0] window,
  input  logic [C_ADDR_WIDTH-1:0] orig_addr,
  output logic [C_ADDR_WIDTH-1:0] next_addr
);

  logic [C_ADDR_WIDTH-1:0] seq_s;
  logic [C_ADDR_WIDTH-1:0] span_s;

  assign seq_s  = addr + size;
  assign span_s = (seq_s - base) + size;

  // Select the next address; a zero window degrades wrap mode to plain sequential.
  always_comb begin
    next_addr = addr;
    case (mode_t'(mode))
      MODE_FIXED: next_addr = orig_addr;
      MODE_SEQ:   next_addr = seq_s;
      MODE_WRAP: begin
        if ((window != {C_ADDR_WIDTH{1'b0}}) && (span_s > window)) begin
          next_addr = base;
        end else begin
          next_addr = seq_s;
        end
      end
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/dma_bench_replayer.sv
// Captures one descriptor and replays it N times towards the DMA engine.
// Optional per-iteration min/max statistics: define DMA_BENCH_ITER_STATS_EN.
module dma_bench_replayer
  import dma_bench_pkg::*;
#(
  parameter int C_ITER_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 64,
  parameter int C_CYC_WIDTH  = 48
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [1:0]              CFG_MODE,
  input  logic [C_ITER_WIDTH-1:0] CFG_NITERATIONS,
  input  logic [C_ADDR_WIDTH-1:0] CFG_WINDOW_SIZE,
  input  logic [7:0]              ORIGINAL_CONTROL_BYTE,
  output logic [7:0]              FAKED_CONTROL_BYTE,
  input  logic                    ORIGINAL_ENGINE_VALID,
  output logic                    FAKED_ENGINE_VALID,
  input  logic [C_ADDR_WIDTH-1:0] ORIGINAL_SIZE_AT_DESCRIPTOR,
  input  logic [C_ADDR_WIDTH-1:0] ORIGINAL_ADDR_AT_DESCRIPTOR,
  output logic [C_ADDR_WIDTH-1:0] FAKED_SIZE_AT_DESCRIPTOR,
  output logic [C_ADDR_WIDTH-1:0] FAKED_ADDR_AT_DESCRIPTOR,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [C_ITER_WIDTH-1:0] ITERATIONS_DONE,
  output logic [C_CYC_WIDTH-1:0]  ELAPSED_CYCLES,
  output logic [C_CYC_WIDTH-1:0]  MIN_ITER_CYCLES,
  output logic [C_CYC_WIDTH-1:0]  MAX_ITER_CYCLES
);

  state_t                  state_r, state_nxt_s;
  logic [1:0]              mode_r, mode_nxt_s;
  logic [C_ITER_WIDTH-1:0] niter_r, niter_nxt_s;
  logic [C_ITER_WIDTH-1:0] iter_r, iter_nxt_s;
  logic [C_ITER_WIDTH-1:0] iters_done_r, iters_done_nxt_s;
  logic [C_ADDR_WIDTH-1:0] window_r, window_nxt_s;
  logic [C_ADDR_WIDTH-1:0] base_r, base_nxt_s;
  logic [C_ADDR_WIDTH-1:0] size_r, size_nxt_s;
  logic [C_ADDR_WIDTH-1:0] addr_r, addr_nxt_s;
  logic [C_CYC_WIDTH-1:0]  elapsed_r, elapsed_nxt_s;
  logic                    valid_r, valid_nxt_s;
  logic                    busy_r, busy_nxt_s;
  logic                    done_r, done_nxt_s;

  logic                    eop_s;
  logic                    last_s;
  logic                    pass_s;
  logic                    start_s;
  logic [C_ADDR_WIDTH-1:0] gen_addr_s;

  assign eop_s   = ORIGINAL_CONTROL_BYTE[C_EOP_BIT];
  assign last_s  = (iter_r == niter_r);
  // Only IDLE can be in passthrough: RUN is never entered with mode 0.
  assign pass_s  = (state_r == IDLE) && (CFG_MODE == MODE_PASS);
  assign start_s = (state_r == IDLE) && ORIGINAL_ENGINE_VALID && (CFG_MODE != MODE_PASS);

  dma_bench_addr_gen #(
    .C_ADDR_WIDTH (C_ADDR_WIDTH)
  ) u_addr_gen (
    .mode      (mode_r),
    .addr      (addr_r),
    .size      (size_r),
    .base      (base_r),
    .window    (window_r),
    .orig_addr (ORIGINAL_ADDR_AT_DESCRIPTOR),
    .next_addr (gen_addr_s)
  );

  // Next-state and datapath update for the replay sequencer.
  always_comb begin
    state_nxt_s      = state_r;
    mode_nxt_s       = mode_r;
    niter_nxt_s      = niter_r;
    iter_nxt_s       = iter_r;
    iters_done_nxt_s = iters_done_r;
    window_nxt_s     = window_r;
    base_nxt_s       = base_r;
    size_nxt_s       = size_r;
    addr_nxt_s       = addr_r;
    elapsed_nxt_s    = elapsed_r;
    valid_nxt_s      = valid_r;
    busy_nxt_s       = busy_r;
    done_nxt_s       = 1'b0;
    case (state_r)
      IDLE: begin
        size_nxt_s  = ORIGINAL_SIZE_AT_DESCRIPTOR;
        addr_nxt_s  = ORIGINAL_ADDR_AT_DESCRIPTOR;
        valid_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
        iter_nxt_s  = C_ITER_WIDTH'(1);
        if (start_s) begin
          state_nxt_s      = RUN;
          mode_nxt_s       = CFG_MODE;
          if (CFG_NITERATIONS == {C_ITER_WIDTH{1'b0}}) begin
            niter_nxt_s = C_ITER_WIDTH'(1);
          end else begin
            niter_nxt_s = CFG_NITERATIONS;
          end
          window_nxt_s     = CFG_WINDOW_SIZE;
          base_nxt_s       = ORIGINAL_ADDR_AT_DESCRIPTOR;
          valid_nxt_s      = 1'b1;
          busy_nxt_s       = 1'b1;
          elapsed_nxt_s    = {C_CYC_WIDTH{1'b0}};
          iters_done_nxt_s = {C_ITER_WIDTH{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (&elapsed_r) begin
          elapsed_nxt_s = elapsed_r;
        end else begin
          elapsed_nxt_s = elapsed_r + C_CYC_WIDTH'(1);
        end
        if (eop_s) begin
          iters_done_nxt_s = iters_done_r + C_ITER_WIDTH'(1);
          if (last_s) begin
            state_nxt_s = FINISH;
            valid_nxt_s = 1'b0;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
          end else begin
            iter_nxt_s = iter_r + C_ITER_WIDTH'(1);
            size_nxt_s = ORIGINAL_SIZE_AT_DESCRIPTOR;
            addr_nxt_s = gen_addr_s;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      FINISH: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        valid_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r      <= IDLE;
      mode_r       <= 2'd0;
      niter_r      <= {C_ITER_WIDTH{1'b0}};
      iter_r       <= C_ITER_WIDTH'(1);
      iters_done_r <= {C_ITER_WIDTH{1'b0}};
      window_r     <= {C_ADDR_WIDTH{1'b0}};
      base_r       <= {C_ADDR_WIDTH{1'b0}};
      size_r       <= {C_ADDR_WIDTH{1'b0}};
      addr_r       <= {C_ADDR_WIDTH{1'b0}};
      elapsed_r    <= {C_CYC_WIDTH{1'b0}};
      valid_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      mode_r       <= mode_nxt_s;
      niter_r      <= niter_nxt_s;
      iter_r       <= iter_nxt_s;
      iters_done_r <= iters_done_nxt_s;
      window_r     <= window_nxt_s;
      base_r       <= base_nxt_s;
      size_r       <= size_nxt_s;
      addr_r       <= addr_nxt_s;
      elapsed_r    <= elapsed_nxt_s;
      valid_r      <= valid_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
    end
  end

  // Intermediate EOPs are masked so the user sees a single completion.
  assign FAKED_CONTROL_BYTE       = pass_s ? ORIGINAL_CONTROL_BYTE :
                                    {4'h0, (eop_s && (state_r == RUN) && last_s), 3'h0};
  assign FAKED_ENGINE_VALID       = pass_s ? ORIGINAL_ENGINE_VALID : valid_r;
  assign FAKED_SIZE_AT_DESCRIPTOR = pass_s ? ORIGINAL_SIZE_AT_DESCRIPTOR : size_r;
  assign FAKED_ADDR_AT_DESCRIPTOR = pass_s ? ORIGINAL_ADDR_AT_DESCRIPTOR : addr_r;
  assign BUSY                     = busy_r;
  assign DONE                     = done_r;
  assign ITERATIONS_DONE          = iters_done_r;
  assign ELAPSED_CYCLES           = elapsed_r;

`ifdef DMA_BENCH_ITER_STATS_EN
  logic [C_CYC_WIDTH-1:0] iter_cyc_r;
  logic [C_CYC_WIDTH-1:0] min_r;
  logic [C_CYC_WIDTH-1:0] max_r;
  logic [C_CYC_WIDTH-1:0] iter_len_s;

  // Length of the current iteration including the EOP cycle.
  assign iter_len_s = iter_cyc_r + C_CYC_WIDTH'(1);

  // Per-iteration cycle counter and min/max tracking.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      iter_cyc_r <= {C_CYC_WIDTH{1'b0}};
      min_r      <= {C_CYC_WIDTH{1'b1}};
      max_r      <= {C_CYC_WIDTH{1'b0}};
    end else if (start_s) begin
      iter_cyc_r <= {C_CYC_WIDTH{1'b0}};
      min_r      <= {C_CYC_WIDTH{1'b1}};
      max_r      <= {C_CYC_WIDTH{1'b0}};
    end else if (state_r == RUN) begin
      if (eop_s) begin
        iter_cyc_r <= {C_CYC_WIDTH{1'b0}};
        if (iter_len_s < min_r) begin
          min_r <= iter_len_s;
        end
        if (iter_len_s > max_r) begin
          max_r <= iter_len_s;
        end
      end else if (!(&iter_cyc_r)) begin
        iter_cyc_r <= iter_len_s;
      end
    end
  end

  assign MIN_ITER_CYCLES = min_r;
  assign MAX_ITER_CYCLES = max_r;
`else
  assign MIN_ITER_CYCLES = {C_CYC_WIDTH{1'b0}};
  assign MAX_ITER_CYCLES = {C_CYC_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_dma_bench_replayer.sv
// Directed self-checking bench for dma_bench_replayer (default parameters).
module tb_dma_bench_replayer;

  logic        CLK;
  logic        RST_N;
  logic [1:0]  CFG_MODE;
  logic [31:0] CFG_NITERATIONS;
  logic [63:0] CFG_WINDOW_SIZE;
  logic [7:0]  ORIGINAL_CONTROL_BYTE;
  logic [7:0]  FAKED_CONTROL_BYTE;
  logic        ORIGINAL_ENGINE_VALID;
  logic        FAKED_ENGINE_VALID;
  logic [63:0] ORIGINAL_SIZE_AT_DESCRIPTOR;
  logic [63:0] ORIGINAL_ADDR_AT_DESCRIPTOR;
  logic [63:0] FAKED_SIZE_AT_DESCRIPTOR;
  logic [63:0] FAKED_ADDR_AT_DESCRIPTOR;
  logic        BUSY;
  logic        DONE;
  logic [31:0] ITERATIONS_DONE;
  logic [47:0] ELAPSED_CYCLES;
  logic [47:0] MIN_ITER_CYCLES;
  logic [47:0] MAX_ITER_CYCLES;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int gaps [8];
  logic [63:0] exp_addr [8];
  logic [63:0] exp_min;
  logic [63:0] exp_max;
  logic [63:0] exp_min_rst;

  dma_bench_replayer dut (
    .CLK                         (CLK),
    .RST_N                       (RST_N),
    .CFG_MODE                    (CFG_MODE),
    .CFG_NITERATIONS             (CFG_NITERATIONS),
    .CFG_WINDOW_SIZE             (CFG_WINDOW_SIZE),
    .ORIGINAL_CONTROL_BYTE       (ORIGINAL_CONTROL_BYTE),
    .FAKED_CONTROL_BYTE          (FAKED_CONTROL_BYTE),
    .ORIGINAL_ENGINE_VALID       (ORIGINAL_ENGINE_VALID),
    .FAKED_ENGINE_VALID          (FAKED_ENGINE_VALID),
    .ORIGINAL_SIZE_AT_DESCRIPTOR (ORIGINAL_SIZE_AT_DESCRIPTOR),
    .ORIGINAL_ADDR_AT_DESCRIPTOR (ORIGINAL_ADDR_AT_DESCRIPTOR),
    .FAKED_SIZE_AT_DESCRIPTOR    (FAKED_SIZE_AT_DESCRIPTOR),
    .FAKED_ADDR_AT_DESCRIPTOR    (FAKED_ADDR_AT_DESCRIPTOR),
    .BUSY                        (BUSY),
    .DONE                        (DONE),
    .ITERATIONS_DONE             (ITERATIONS_DONE),
    .ELAPSED_CYCLES              (ELAPSED_CYCLES),
    .MIN_ITER_CYCLES             (MIN_ITER_CYCLES),
    .MAX_ITER_CYCLES             (MAX_ITER_CYCLES)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count DONE pulses so each run can be checked for exactly one.
  always @(negedge CLK) begin
    if (DONE === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Start a run, drive EOPs after gaps[k] RUN cycles each, check addresses and completion.
  task automatic run_case(input string tag, input logic [1:0] mode, input logic [31:0] niter,
                          input logic [63:0] window, input logic [63:0] base,
                          input logic [63:0] size, input int n_eop);
    int total;
    int d0;
    total = 0;
    d0 = done_cnt;
    CFG_MODE = mode;
    CFG_NITERATIONS = niter;
    CFG_WINDOW_SIZE = window;
    ORIGINAL_ADDR_AT_DESCRIPTOR = base;
    ORIGINAL_SIZE_AT_DESCRIPTOR = size;
    ORIGINAL_CONTROL_BYTE = 8'h00;
    ORIGINAL_ENGINE_VALID = 1'b1;
    tick();
    ORIGINAL_ENGINE_VALID = 1'b0;
    check_eq({tag, "_busy"}, {63'd0, BUSY}, 64'd1);
    check_eq({tag, "_valid"}, {63'd0, FAKED_ENGINE_VALID}, 64'd1);
    for (int k = 0; k < n_eop; k++) begin
      for (int c = 1; c < gaps[k]; c++) tick();
      ORIGINAL_CONTROL_BYTE = 8'h08;
      #1;
      check_eq($sformatf("%s_addr%0d", tag, k), FAKED_ADDR_AT_DESCRIPTOR, exp_addr[k]);
      check_eq($sformatf("%s_size%0d", tag, k), FAKED_SIZE_AT_DESCRIPTOR, size);
      check_eq($sformatf("%s_ctrl%0d", tag, k), {56'd0, FAKED_CONTROL_BYTE},
               (k == n_eop - 1) ? 64'h08 : 64'h00);
      total += gaps[k];
      tick();
      ORIGINAL_CONTROL_BYTE = 8'h00;
      if (k < n_eop - 1) begin
        check_eq($sformatf("%s_itd%0d", tag, k), {32'd0, ITERATIONS_DONE}, 64'(k + 1));
      end
    end
    check_eq({tag, "_done"}, {63'd0, DONE}, 64'd1);
    check_eq({tag, "_valid_off"}, {63'd0, FAKED_ENGINE_VALID}, 64'd0);
    check_eq({tag, "_busy_off"}, {63'd0, BUSY}, 64'd0);
    check_eq({tag, "_iters"}, {32'd0, ITERATIONS_DONE}, 64'(n_eop));
    check_eq({tag, "_elapsed"}, {16'd0, ELAPSED_CYCLES}, 64'(total));
    tick();
    check_eq({tag, "_done_low"}, {63'd0, DONE}, 64'd0);
    check_eq({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check_eq({tag, "_elapsed_hold"}, {16'd0, ELAPSED_CYCLES}, 64'(total));
  endtask

  initial begin
`ifdef DMA_BENCH_ITER_STATS_EN
    exp_min = 64'd5;
    exp_max = 64'd9;
    exp_min_rst = 64'h0000_FFFF_FFFF_FFFF;
`else
    exp_min = 64'd0;
    exp_max = 64'd0;
    exp_min_rst = 64'd0;
`endif
    RST_N = 1'b0;
    CFG_MODE = 2'd1;
    CFG_NITERATIONS = 32'd0;
    CFG_WINDOW_SIZE = 64'd0;
    ORIGINAL_CONTROL_BYTE = 8'h08;
    ORIGINAL_ENGINE_VALID = 1'b1;
    ORIGINAL_SIZE_AT_DESCRIPTOR = 64'h55;
    ORIGINAL_ADDR_AT_DESCRIPTOR = 64'hABCD;
    tick();
    tick();
    check_eq("rst_busy", {63'd0, BUSY}, 64'd0);
    check_eq("rst_done", {63'd0, DONE}, 64'd0);
    check_eq("rst_valid", {63'd0, FAKED_ENGINE_VALID}, 64'd0);
    check_eq("rst_addr", FAKED_ADDR_AT_DESCRIPTOR, 64'd0);
    check_eq("rst_ctrl", {56'd0, FAKED_CONTROL_BYTE}, 64'd0);
    check_eq("rst_iters", {32'd0, ITERATIONS_DONE}, 64'd0);
    check_eq("rst_elapsed", {16'd0, ELAPSED_CYCLES}, 64'd0);
    check_eq("rst_min", {16'd0, MIN_ITER_CYCLES}, exp_min_rst);
    check_eq("rst_max", {16'd0, MAX_ITER_CYCLES}, 64'd0);
    ORIGINAL_ENGINE_VALID = 1'b0;
    ORIGINAL_CONTROL_BYTE = 8'h00;
    RST_N = 1'b1;
    tick();

    // Mode 1, fixed address
    for (int k = 0; k < 4; k++) begin
      gaps[k] = 10;
      exp_addr[k] = 64'h1000;
    end
    run_case("fixed", 2'd1, 32'd4, 64'd0, 64'h1000, 64'd256, 4);

    // Mode 2, sequential
    for (int k = 0; k < 3; k++) gaps[k] = 4 + k;
    exp_addr[0] = 64'h2000;
    exp_addr[1] = 64'h2100;
    exp_addr[2] = 64'h2200;
    run_case("seq", 2'd2, 32'd3, 64'd0, 64'h2000, 64'h100, 3);

    // Mode 3, window wrap
    for (int k = 0; k < 5; k++) gaps[k] = 3;
    exp_addr[0] = 64'h0;
    exp_addr[1] = 64'h100;
    exp_addr[2] = 64'h200;
    exp_addr[3] = 64'h0;
    exp_addr[4] = 64'h100;
    run_case("wrap", 2'd3, 32'd5, 64'h300, 64'h0, 64'h100, 5);

    // niter=0 behaves as a single iteration
    gaps[0] = 3;
    exp_addr[0] = 64'h4000;
    run_case("niter0", 2'd1, 32'd0, 64'd0, 64'h4000, 64'h40, 1);

    // Iteration statistics with gaps 5, 9, 7
    gaps[0] = 5;
    gaps[1] = 9;
    gaps[2] = 7;
    for (int k = 0; k < 3; k++) exp_addr[k] = 64'h8000;
    run_case("stats", 2'd1, 32'd3, 64'd0, 64'h8000, 64'h10, 3);
    check_eq("stats_min", {16'd0, MIN_ITER_CYCLES}, exp_min);
    check_eq("stats_max", {16'd0, MAX_ITER_CYCLES}, exp_max);

    // Mode 0 passthrough
    CFG_MODE = 2'd0;
    ORIGINAL_CONTROL_BYTE = 8'hA5;
    ORIGINAL_ENGINE_VALID = 1'b1;
    ORIGINAL_SIZE_AT_DESCRIPTOR = 64'h1234;
    ORIGINAL_ADDR_AT_DESCRIPTOR = 64'hDEAD_BEEF_0000;
    #1;
    check_eq("pass_ctrl", {56'd0, FAKED_CONTROL_BYTE}, 64'hA5);
    check_eq("pass_valid", {63'd0, FAKED_ENGINE_VALID}, 64'd1);
    check_eq("pass_size", FAKED_SIZE_AT_DESCRIPTOR, 64'h1234);
    check_eq("pass_addr", FAKED_ADDR_AT_DESCRIPTOR, 64'hDEAD_BEEF_0000);
    tick();
    ORIGINAL_CONTROL_BYTE = 8'h5A;
    ORIGINAL_ENGINE_VALID = 1'b0;
    ORIGINAL_ADDR_AT_DESCRIPTOR = 64'h77;
    #1;
    check_eq("pass_ctrl2", {56'd0, FAKED_CONTROL_BYTE}, 64'h5A);
    check_eq("pass_valid2", {63'd0, FAKED_ENGINE_VALID}, 64'd0);
    check_eq("pass_addr2", FAKED_ADDR_AT_DESCRIPTOR, 64'h77);
    check_eq("pass_busy", {63'd0, BUSY}, 64'd0);
    ORIGINAL_CONTROL_BYTE = 8'h00;
    tick();

    // Reset in the middle of a run: engine valid drops, no DONE
    begin
      int d0;
      d0 = done_cnt;
      CFG_MODE = 2'd2;
      CFG_NITERATIONS = 32'd4;
      ORIGINAL_ENGINE_VALID = 1'b1;
      tick();
      ORIGINAL_ENGINE_VALID = 1'b0;
      check_eq("mid_valid_on", {63'd0, FAKED_ENGINE_VALID}, 64'd1);
      tick();
      tick();
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      check_eq("mid_valid_off", {63'd0, FAKED_ENGINE_VALID}, 64'd0);
      check_eq("mid_busy", {63'd0, BUSY}, 64'd0);
      check_eq("mid_elapsed", {16'd0, ELAPSED_CYCLES}, 64'd0);
      for (int i = 0; i < 4; i++) tick();
      check_eq("mid_no_done", 64'(done_cnt - d0), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
